// File: rtl/pl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result-source code and the memory-wait FSM states.
package pl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   typedef enum logic [1:0] {
      S_RUN  = 2'b00,
      S_WAIT = 2'b01,
      S_ERR  = 2'b10
   } hz_state_t;

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// Pipeline-side hazard signals: register addresses and enables from the
// datapath, plus the stall/flush/forward controls returned to it.
interface pl_hazard_ctrl_if;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE, MemReqM, MemReadyM;
   logic       StallF, StallD, StallE, StallM, StallW;
   logic       FlushD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       MemErr;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, StallW,
      input  FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemErr
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, StallW,
      output FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemErr
   );
endinterface

// File: rtl/pl_fwd_sel.sv
// Per-operand forwarding comparator for the E stage; the M-stage producer
// is younger than W and therefore wins when both match.
module pl_fwd_sel
   import pl_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs_e)
         fwd = FWD_M;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == rs_e)
         fwd = FWD_W;
   end

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Hazard/stall controller: load-use stalls, branch flushes, forwarding and a
// memory-wait FSM with timeout. PL_HAZARD_PERF_EN adds event counters.
//
// state | meaning
// RUN   | normal flow; a not-ready memory request stalls and moves to WAIT
// WAIT  | pipeline frozen awaiting MemReadyM; counter tracks wait cycles
// ERR   | memory timed out; frozen with MemErr until reset
module pl_hazard_ctrl
   import pl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic reset,
   pl_hazard_ctrl_if.slave hz
`ifdef PL_HAZARD_PERF_EN
   ,
   output logic [31:0] LoadUseCnt,
   output logic [31:0] MemWaitCnt,
   output logic [31:0] FlushCnt
`endif
);

   hz_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lw_stall, mem_stall;
   logic             case_mem, case_br, case_lw;

   pl_fwd_sel u_fwd_a (
      .rs_e(hz.Rs1E), .rd_m(hz.RdM), .rd_w(hz.RdW),
      .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW),
      .fwd(hz.ForwardAE)
   );

   pl_fwd_sel u_fwd_b (
      .rs_e(hz.Rs2E), .rd_m(hz.RdM), .rd_w(hz.RdW),
      .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW),
      .fwd(hz.ForwardBE)
   );

   assign lw_stall  = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
   assign mem_stall = (state == S_RUN && hz.MemReqM && !hz.MemReadyM) ||
                      (state == S_WAIT) || (state == S_ERR);

   assign case_mem = mem_stall;
   assign case_br  = !mem_stall && hz.PCSrcE;
   assign case_lw  = !mem_stall && !hz.PCSrcE && lw_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_RUN: begin
            if (hz.MemReqM && !hz.MemReadyM) begin
               state_nxt = S_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (hz.MemReadyM) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_RUN;
      endcase
   end

   // ERR is only left through reset, so the sticky flag is the state itself.
   assign hz.MemErr = (state == S_ERR);

   always_comb begin
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.StallW = 1'b0;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b0;
      if (case_mem) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushW = 1'b1;
      end else if (case_br) begin
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
      end else if (case_lw) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.FlushE = 1'b1;
      end
   end

`ifdef PL_HAZARD_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         LoadUseCnt <= '0;
         MemWaitCnt <= '0;
         FlushCnt   <= '0;
      end else begin
         if (case_lw  && LoadUseCnt != '1) LoadUseCnt <= LoadUseCnt + 32'd1;
         if (case_mem && MemWaitCnt != '1) MemWaitCnt <= MemWaitCnt + 32'd1;
         if (case_br  && FlushCnt   != '1) FlushCnt   <= FlushCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl: forwarding, load-use, branch flush,
// memory wait, timeout/ERR and async reset (plus counters with PL_HAZARD_PERF_EN).
module tb_pl_hazard_ctrl;
   import pl_pkg::*;

   // control word order: {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,FlushW}
   localparam logic [31:0] C_NONE = 32'b0000_0000;
   localparam logic [31:0] C_MEM  = 32'b1111_0001;
   localparam logic [31:0] C_BR   = 32'b0000_0110;
   localparam logic [31:0] C_LW   = 32'b1100_0010;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   stalls;

   pl_hazard_ctrl_if hz ();

`ifdef PL_HAZARD_PERF_EN
   logic [31:0] LoadUseCnt, MemWaitCnt, FlushCnt;
`endif

   pl_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk),
      .reset(reset),
      .hz(hz.slave)
`ifdef PL_HAZARD_PERF_EN
      ,
      .LoadUseCnt(LoadUseCnt),
      .MemWaitCnt(MemWaitCnt),
      .FlushCnt(FlushCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ctrl();
      return {24'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
              hz.FlushD, hz.FlushE, hz.FlushW};
   endfunction

   task automatic clear_inputs();
      hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
      hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
      hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
   endtask

   // inputs change right after the falling edge; checks 1 ns later
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      #1;
      chk("rst_ctrl", ctrl(), C_NONE);
      chk("rst_memerr", 32'(hz.MemErr), 32'd0);
      chk("rst_fwda", 32'(hz.ForwardAE), 32'(FWD_RF));
      chk("rst_fwdb", 32'(hz.ForwardBE), 32'(FWD_RF));
      #20 reset = 1'b0;

      // forwarding
      next_cycle();
      hz.Rs1E = 5'd5; hz.Rs2E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
      hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
      #1;
      chk("fwda_m_wins", 32'(hz.ForwardAE), 32'b10);
      chk("fwdb_m_wins", 32'(hz.ForwardBE), 32'b10);
      hz.RdM = 5'd0;
      #1 chk("fwda_rdm0_w", 32'(hz.ForwardAE), 32'b01);
      hz.RegWriteW = 1'b0;
      #1 chk("fwda_nowr", 32'(hz.ForwardAE), 32'b00);
      hz.Rs2E = 5'd7; hz.RdW = 5'd7; hz.RegWriteW = 1'b1;
      #1;
      chk("fwdb_w", 32'(hz.ForwardBE), 32'b01);
      chk("fwda_nomatch", 32'(hz.ForwardAE), 32'b00);
      hz.Rs1E = 5'd0; hz.RdW = 5'd0;
      #1 chk("fwda_x0", 32'(hz.ForwardAE), 32'b00);
      chk("fwd_noctrl", ctrl(), C_NONE);

      // load-use
      next_cycle();
      clear_inputs();
      hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd3; hz.Rs2D = 5'd3;
      #1 chk("lw_rs2", ctrl(), C_LW);
      next_cycle();
      hz.ResultSrcE = 2'b00;
      #1 chk("lw_released", ctrl(), C_NONE);
      hz.ResultSrcE = RESULT_SRC_LOAD; hz.Rs2D = 5'd0; hz.Rs1D = 5'd3;
      #1 chk("lw_rs1", ctrl(), C_LW);
      hz.RdE = 5'd0; hz.Rs1D = 5'd0;
      #1 chk("lw_rde0", ctrl(), C_NONE);
      hz.RdE = 5'd3; hz.Rs1D = 5'd3; hz.ResultSrcE = 2'b00;
      #1 chk("lw_notload", ctrl(), C_NONE);

      // branch beats load-use
      hz.ResultSrcE = RESULT_SRC_LOAD; hz.PCSrcE = 1'b1;
      #1 chk("br_over_lw", ctrl(), C_BR);

      // zero-wait access: no stall
      next_cycle();
      clear_inputs();
      hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
      #1 chk("mem_zero_wait", ctrl(), C_NONE);

      // 3 not-ready cycles then ready: 4 stall cycles
      next_cycle();
      hz.MemReadyM = 1'b0;
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         hz.MemReadyM = (i == 3);
         hz.PCSrcE    = (i == 1);
         #1;
         if (hz.StallM && hz.FlushW) stalls++;
         if (i == 1) chk("mem_over_br", ctrl(), C_MEM);
         next_cycle();
      end
      hz.MemReqM = 1'b0; hz.PCSrcE = 1'b0;
      #1;
      chk("mem_stall_cycles", 32'(stalls), 32'd4);
      chk("mem_back_run", ctrl(), C_NONE);
      chk("mem_no_err", 32'(hz.MemErr), 32'd0);

      // timeout: edges 1..4 in WAIT, edge 5 enters ERR
      hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
      for (int i = 0; i < 4; i++) next_cycle();
      #1 chk("tmo_not_yet", 32'(hz.MemErr), 32'd0);
      next_cycle();
      #1;
      chk("tmo_err", 32'(hz.MemErr), 32'd1);
      chk("tmo_ctrl", ctrl(), C_MEM);
      hz.MemReadyM = 1'b1; hz.MemReqM = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      chk("err_sticky", 32'(hz.MemErr), 32'd1);
      chk("err_frozen", ctrl(), C_MEM);
      #1 reset = 1'b1;
      #1;
      chk("areset_err", 32'(hz.MemErr), 32'd0);
      chk("areset_ctrl", ctrl(), C_NONE);
      #1 reset = 1'b0;

      // reset mid-WAIT
      next_cycle();
      hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
      next_cycle();
      hz.MemReqM = 1'b0;
      #1 chk("wait_ctrl", ctrl(), C_MEM);
      reset = 1'b1;
      #1 chk("wait_reset", ctrl(), C_NONE);
      reset = 1'b0;

`ifdef PL_HAZARD_PERF_EN
      clear_inputs();
      do_reset();
      #1 chk("perf_rst", MemWaitCnt, 32'd0);
      next_cycle();
      hz.MemReqM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         hz.MemReadyM = (i == 2);
         next_cycle();
      end
      clear_inputs();
      hz.ResultSrcE = RESULT_SRC_LOAD; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
      next_cycle();
      clear_inputs();
      hz.PCSrcE = 1'b1;
      next_cycle();
      clear_inputs();
      #1;
      chk("perf_memwait", MemWaitCnt, 32'd3);
      chk("perf_loaduse", LoadUseCnt, 32'd1);
      chk("perf_flush", FlushCnt, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule
